// File: rtl/uart_transmit.sv
// 8N1 UART transmitter, LSB first, valid/ready byte input.
// Define UART_TX_PARITY_EN to add a parity bit (8E1 / 8O1).
module uart_transmit #(
   parameter int CLKS_PER_BIT = 434,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       txd,
   output logic       busy,
   output logic       tx_done
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      idx;
   logic [7:0]      shift;
`ifdef UART_TX_PARITY_EN
   logic            par;
`endif

   logic bit_end;
   assign bit_end  = (cnt == LAST);
   assign tx_ready = (state == IDLE);
   assign busy     = ~tx_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         shift   <= '0;
         txd     <= 1'b1;
         tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         tx_done <= 1'b0;
         unique case (state)
            IDLE: begin
               txd <= 1'b1;
               if (tx_valid) begin
                  shift <= tx_data;
`ifdef UART_TX_PARITY_EN
                  par   <= (^tx_data) ^ PARITY_ODD;
`endif
                  cnt   <= '0;
                  idx   <= '0;
                  txd   <= 1'b0;
                  state <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt   <= '0;
                  txd   <= shift[0];
                  state <= DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt   <= '0;
                  idx   <= idx + 1'b1;
                  shift <= shift >> 1;
                  if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     txd   <= par;
                     state <= PARITY;
`else
                     txd   <= 1'b1;
                     state <= STOP;
`endif
                  end else begin
                     txd <= shift[1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  cnt   <= '0;
                  txd   <= 1'b1;
                  state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  cnt     <= '0;
                  tx_done <= 1'b1;
                  // a still-pending byte starts its frame on this edge: no idle gap
                  if (tx_valid) begin
                     shift <= tx_data;
`ifdef UART_TX_PARITY_EN
                     par   <= (^tx_data) ^ PARITY_ODD;
`endif
                     idx   <= '0;
                     txd   <= 1'b0;
                     state <= START;
                  end else begin
                     txd   <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               txd   <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transmit.sv
// Directed self-checking bench for uart_transmit with N=4.
// Define UART_TX_PARITY_EN to exercise the even-parity frame.
module tb_uart_transmit;

   localparam int N = 4;
`ifdef UART_TX_PARITY_EN
   localparam int F = 11;
`else
   localparam int F = 10;
`endif

   logic       clk;
   logic       reset;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       txd;
   logic       busy;
   logic       tx_done;

   int errors;
   int checks;
   int done_cnt;

   uart_transmit #(
      .CLKS_PER_BIT(N),
      .PARITY_ODD  (1'b0)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .tx_valid(tx_valid),
      .tx_data (tx_data),
      .tx_ready(tx_ready),
      .txd     (txd),
      .busy    (busy),
      .tx_done (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

   // expected line level for frame slot j (0 = start bit)
   function automatic logic frame_bit(input logic [7:0] b, input int j);
      if (j == 0) return 1'b0;
      if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
      if (j == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // leaves time at E0 + 1ns
   task automatic start_byte(input logic [7:0] b);
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({txd, tx_ready, busy, tx_done} !== 4'b1100) begin
         errors++;
         $display("FAIL reset_hold got %b want 1100",
                  {txd, tx_ready, busy, tx_done});
      end
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({txd, tx_ready, busy, tx_done} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_idle c=%0d got %b want 1100", c,
                     {txd, tx_ready, busy, tx_done});
         end
      end
   endtask

   task automatic test_single;
      int d0;
      d0 = done_cnt;
      start_byte(8'h55);
      tx_valid = 1'b0;
      for (int c = 0; c < F * N; c++) begin
         checks++;
         if (txd !== frame_bit(8'h55, c / N)) begin
            errors++;
            $display("FAIL single_txd c=%0d got %b want %b", c, txd,
                     frame_bit(8'h55, c / N));
         end
         checks++;
         if ({tx_ready, busy, tx_done} !== 3'b010) begin
            errors++;
            $display("FAIL single_busy c=%0d got %b want 010", c,
                     {tx_ready, busy, tx_done});
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if ({txd, tx_ready, busy, tx_done} !== 4'b1101) begin
         errors++;
         $display("FAIL single_end got %b want 1101",
                  {txd, tx_ready, busy, tx_done});
      end
      @(posedge clk);
      #1;
      checks++;
      if (tx_done !== 1'b0 || done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL single_pulse got done=%b pulses=%0d want 0 and 1",
                  tx_done, done_cnt - d0);
      end
   endtask

   task automatic test_back_to_back;
      int d0;
      d0 = done_cnt;
      start_byte(8'hA3);
      tx_data = 8'h0F;
      for (int c = 0; c < F * N; c++) begin
         checks++;
         if (txd !== frame_bit(8'hA3, c / N) || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first c=%0d got txd=%b rdy=%b want %b 0",
                     c, txd, tx_ready, frame_bit(8'hA3, c / N));
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if ({txd, tx_ready, tx_done} !== 3'b001) begin
         errors++;
         $display("FAIL b2b_join got %b want 001",
                  {txd, tx_ready, tx_done});
      end
      tx_valid = 1'b0;
      for (int c = 0; c < F * N; c++) begin
         checks++;
         if (txd !== frame_bit(8'h0F, c / N) || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second c=%0d got txd=%b rdy=%b want %b 0",
                     c, txd, tx_ready, frame_bit(8'h0F, c / N));
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if ({txd, tx_ready, tx_done} !== 3'b111) begin
         errors++;
         $display("FAIL b2b_end got %b want 111",
                  {txd, tx_ready, tx_done});
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done_cnt - d0 !== 2) begin
         errors++;
         $display("FAIL b2b_pulses got %0d want 2", done_cnt - d0);
      end
   endtask

   task automatic test_data_stable;
      start_byte(8'h3C);
      tx_valid = 1'b0;
      for (int c = 0; c < F * N; c++) begin
         checks++;
         if (txd !== frame_bit(8'h3C, c / N)) begin
            errors++;
            $display("FAIL stable_txd c=%0d got %b want %b", c, txd,
                     frame_bit(8'h3C, c / N));
         end
         if (c == 0) tx_data = 8'hFF;
         @(posedge clk);
         #1;
      end
      checks++;
      if (tx_done !== 1'b1) begin
         errors++;
         $display("FAIL stable_done got %b want 1", tx_done);
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset_mid;
      int d0;
      d0 = done_cnt;
      start_byte(8'hF0);
      tx_valid = 1'b0;
      repeat (17) @(posedge clk);
      #1;
      checks++;
      if (txd !== 1'b0) begin
         errors++;
         $display("FAIL mid_bit3 got %b want 0", txd);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({txd, tx_ready, busy, tx_done} !== 4'b1100) begin
         errors++;
         $display("FAIL mid_async got %b want 1100",
                  {txd, tx_ready, busy, tx_done});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      checks++;
      if (done_cnt !== d0 || txd !== 1'b1) begin
         errors++;
         $display("FAIL mid_nodone got pulses=%0d txd=%b want 0 1",
                  done_cnt - d0, txd);
      end
      start_byte(8'h81);
      tx_valid = 1'b0;
      for (int c = 0; c < F * N; c++) begin
         checks++;
         if (txd !== frame_bit(8'h81, c / N)) begin
            errors++;
            $display("FAIL mid_resend c=%0d got %b want %b", c, txd,
                     frame_bit(8'h81, c / N));
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if ({tx_ready, tx_done} !== 2'b11) begin
         errors++;
         $display("FAIL mid_resend_end got %b want 11", {tx_ready, tx_done});
      end
      repeat (2) @(posedge clk);
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity;
      logic [7:0] bytes [2];
      logic       pbit  [2];
      bytes[0] = 8'h80;
      pbit[0]  = 1'b1;
      bytes[1] = 8'h55;
      pbit[1]  = 1'b0;
      for (int k = 0; k < 2; k++) begin
         start_byte(bytes[k]);
         tx_valid = 1'b0;
         for (int c = 0; c < 11 * N; c++) begin
            checks++;
            if (c / N == 9 && txd !== pbit[k]) begin
               errors++;
               $display("FAIL parity_bit byte=%h got %b want %b",
                        bytes[k], txd, pbit[k]);
            end else if (c / N != 9 && txd !== frame_bit(bytes[k], c / N)) begin
               errors++;
               $display("FAIL parity_frame c=%0d got %b want %b", c, txd,
                        frame_bit(bytes[k], c / N));
            end
            @(posedge clk);
            #1;
         end
         checks++;
         if ({tx_ready, tx_done} !== 2'b11) begin
            errors++;
            $display("FAIL parity_done got %b want 11", {tx_ready, tx_done});
         end
         repeat (2) @(posedge clk);
      end
   endtask
`endif

   initial begin
      errors   = 0;
      checks   = 0;
      done_cnt = 0;
      reset    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      test_reset();
      test_single();
      test_back_to_back();
      test_data_stable();
      test_reset_mid();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_transmit.md
# uart_transmit

Serial UART transmitter, 8 data bits, 1 stop bit, no parity by default (8N1), LSB first. It is the transmit counterpart to the board's UART receive path and shares its bit timing: 434 clocks per bit, which is 115200 baud at 50 MHz. A byte is accepted from core logic over a valid/ready handshake and serialised onto `txd`, which idles high. Status outputs feed the Phaethon I/O register block.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per serial bit; legal range 2..65535.
- `PARITY_ODD`, 0: parity sense when parity is compiled in (0 = even, 1 = odd). Ignored otherwise.

Ports:
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset. Clock is `clk`.
- `tx_valid`  input  1  `tx_data` holds a byte to send.
- `tx_data`  input  8  byte to transmit; sampled only on handshake.
- `tx_ready`  output  1  block can accept a byte (high only in IDLE).
- `txd`  output  1  serial line, registered; idle/mark = 1.
- `busy`  output  1  frame in progress (inverse of `tx_ready`).
- `tx_done`  output  1  one-cycle pulse at end of stop bit.

## Operation
- States: IDLE, START, DATA, PARITY (only when compiled in), STOP.
- IDLE: `txd`=1, `tx_ready`=1. When `tx_valid`=1 at a rising edge: capture `tx_data` into the shift register, clear the bit counter and the bit index, then go to START.
- START: `txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: `txd` = `shift[0]`. Hold each bit for `CLKS_PER_BIT` cycles, then shift right and increment the 3-bit index. After index 7 completes, go to PARITY if enabled, else to STOP.
- PARITY: `txd` = XOR of the captured byte, XORed with `PARITY_ODD`. Hold for `CLKS_PER_BIT` cycles, then go to STOP.
- STOP: `txd`=1 for `CLKS_PER_BIT` cycles. On the last cycle's edge, go to IDLE and pulse `tx_done`.
- Bit counter: width `$clog2(CLKS_PER_BIT)`, counts 0..`CLKS_PER_BIT`-1, then wraps to 0 and advances the bit. No other wrap exists.
- Changes to `tx_data` or `tx_valid` after the handshake are ignored until the block returns to IDLE.
- `tx_valid` dropping mid-frame has no effect. There is no abort input.
- Reset values: `txd`=1, `tx_ready`=1, `busy`=0, `tx_done`=0, state IDLE, counters 0, shift register 0.
- Reset mid-frame: `txd` returns to 1 asynchronously and the frame is truncated. No `tx_done` is produced and the byte is lost.

## Timing
- E0 is the rising edge where `tx_valid`=1 and `tx_ready`=1.
- After E0: `txd`=0, `tx_ready`=0, `busy`=1. Latency from handshake to start-bit edge is 1 clock.
- Data bit k is driven from E0+(1+k)·N to E0+(2+k)·N, where N=`CLKS_PER_BIT`.
- The frame lasts F·N cycles, with F=10 (11 with parity).
- At edge E0+F·N: state = IDLE, `tx_ready`=1, and `tx_done`=1 for exactly one cycle.
- Back-to-back: if `tx_valid` is still high at E0+F·N, that edge is the next handshake. The next start bit follows with no idle gap, giving continuous line throughput.
- `tx_ready` is a function of state only. It has no combinational path from `tx_valid`.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: PARITY state is present, the frame is 8E1 (or 8O1 when `PARITY_ODD`=1), and F=11.
- Undefined: PARITY state and parity logic are absent, the frame is 8N1, and F=10.

## Test plan
- Reset, idle check: hold `reset` for 3 cycles, then release with `tx_valid`=0 for 50 cycles. `txd`=1, `tx_ready`=1, `busy`=0 and `tx_done`=0 throughout.
- Single byte, N=4: send 0x55. `txd` follows 0,1,0,1,0,1,0,1,0,1, each for 4 cycles, starting 1 cycle after handshake. `tx_done` pulses once at E0+40 and `tx_ready` rises on the same edge.
- Back-to-back, N=4: hold `tx_valid`=1 with 0xA3, then 0x0F. The second start bit begins at E0+40 with no high gap. Decoded bytes are 0xA3 then 0x0F. Exactly 2 `tx_done` pulses.
- Data stability: change `tx_data` from 0x3C to 0xFF one cycle after handshake. The serialised byte is still 0x3C.
- Reset mid-frame: assert `reset` during data bit 3. `txd` goes to 1 immediately, with no `tx_done`. After release, a new 0x81 transmits correctly.
- Parity (with `UART_TX_PARITY_EN`, N=4, even): send 0x80, then 0x55. The parity bit is 1 for 0x80 and 0 for 0x55. `tx_done` pulses at E0+44.
